// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg
// Shared definitions for the timer scheduler: FSM state encoding and the
// round-robin winner pick used when the shared timer is free.
// No ports (package).

package timer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest supported requester count; the pick function works on a
    // vector padded to this width so one function serves every N_REQ.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan starting at the requester just above `last`, wrapping at n_req.
    // The previous owner is therefore checked last.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                         input logic [IDX_W-1:0]   last,
                                         input int unsigned        n_req);
        rr_pick_t    p;
        int unsigned cand;
        p.valid = 1'b0;
        p.idx   = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if ((k <= n_req) && !p.valid) begin
                cand = (32'(last) + k) % n_req;
                if (req_vec[IDX_W'(cand)]) begin
                    p.valid = 1'b1;
                    p.idx   = IDX_W'(cand);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/timer_scheduler_ticker.sv
// interval_ticker
// Free-running unit ticker: counts 0..TICK-1 while enabled and emits a
// one-cycle tick on the wrap back to 0. Replaces ad-hoc one-second counters.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear of the count (wins over en)
//   en    - count enable
//   tick  - high in the cycle the count sits at TICK-1 while enabled

module interval_ticker #(
    parameter int unsigned TICK = 300000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler
// Shares one interval timer among N_REQ requesters. A free timer is granted
// round-robin; the owner runs for dur*TICK cycles and receives a one-cycle
// done pulse. Dropping req while owning the timer cancels without done.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   req   - level request per requester
//   dur   - packed durations in timer units, requester i at [i*DUR_W +: DUR_W]
//   grant - one-hot, high while requester i owns the timer
//   done  - one-hot, one-cycle pulse when the owner's interval expires
//   busy  - high while in RUN or DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | timer free; arbitrate pending requests
// RUN   | owner holds the timer; ticker and unit_cnt advancing
// DONE  | one-cycle done pulse to the owner; pointer moves on

module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned TICK  = 300000000,
    parameter int unsigned DUR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DUR_W-1:0] dur,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy
);

    localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state_q, state_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      last_owner_q, last_owner_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [DUR_W-1:0]   unit_cnt_q, unit_cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;

    logic [MAX_REQ-1:0] req_pad;
    rr_pick_t           pick;
    logic [DUR_W-1:0]   dur_sel;
    logic [DUR_W-1:0]   unit_inc;
    logic               tick_clr;
    logic               tick_en;
    logic               tick;

    interval_ticker #(
        .TICK (TICK)
    ) u_ticker (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        req_pad              = '0;
        req_pad[N_REQ-1:0]   = req;
        pick                 = rr_pick(req_pad, IDX_W'(last_owner_q), N_REQ);
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        dur_d        = dur_q;
        unit_cnt_d   = unit_cnt_q;
        tick_clr     = 1'b0;
        tick_en      = 1'b0;
        dur_sel      = '0;
        unit_inc     = unit_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        if (pick.idx == IDX_W'(i)) begin
                            owner_d = OW'(i);
                        end
                    end
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        if (owner_d == OW'(i)) begin
                            dur_sel = dur[i*DUR_W +: DUR_W];
                        end
                    end
                    dur_d      = dur_sel;
                    unit_cnt_d = '0;
                    tick_clr   = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                tick_en = 1'b1;
                // Cancel outranks a completing tick in the same cycle.
                if (!req[owner_q]) begin
                    last_owner_d = owner_q;
                    state_d      = IDLE;
                end else if (dur_q == '0) begin
                    state_d = DONE;
                end else if (tick) begin
                    unit_cnt_d = unit_inc;
                    if (unit_inc == dur_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered: decode from the next state.
        for (int i = 0; i < int'(N_REQ); i++) begin
            grant_d[i] = (state_d == RUN)  && (owner_d == OW'(i));
            done_d[i]  = (state_d == DONE) && (owner_q == OW'(i));
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= OW'(N_REQ - 1);
            dur_q        <= '0;
            unit_cnt_q   <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            dur_q        <= dur_d;
            unit_cnt_q   <= unit_cnt_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Round-robin scheduler that shares one interval timer among `N_REQ` requesters (LED illumination phases, Chip2Chip handshake timeouts). Each requester asks for a duration in whole timer units. The block grants the timer to one requester at a time, runs it for `dur × TICK` cycles, and returns a one-cycle `done` pulse to the owner. It sits between the board-level control FSMs and replaces the per-FSM free-running one-second counters.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TICK`, 300000000: clock cycles per timer unit. Benches override it to 4.
- `DUR_W`, 4: width of each duration field, in units.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, `N_REQ`: level request, one bit per requester.
- `dur`, in, `N_REQ*DUR_W`: packed durations. Requester i uses bits [i*DUR_W +: DUR_W].
- `grant`, out, `N_REQ`: one-hot, high while requester i owns the timer.
- `done`, out, `N_REQ`: one-hot, one-cycle pulse when the owner's interval expires.
- `busy`, out, 1: high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any `req` bit is high, pick a winner round-robin, starting at the bit above `last_owner`.
  - Latch the winner index into `owner` and its `dur` field into `dur_q`.
  - Go to RUN. Clear the ticker and `unit_cnt`.
- RUN:
  - `grant[owner]` is high.
  - The ticker pulses once every `TICK` cycles. Each pulse increments `unit_cnt`.
  - When `unit_cnt` reaches `dur_q` (checked combinationally on a tick), go to DONE.
  - If `dur_q == 0`, go to DONE on the first RUN cycle. No tick is counted.
- DONE:
  - `done[owner]` is high for exactly one cycle and `grant` is 0.
  - `last_owner` ← `owner`. Go to IDLE.
- Cancel: if `req[owner]` falls while in RUN, return to IDLE next cycle.
  - No `done` is issued.
  - `last_owner` ← `owner`, so the pointer still advances.
- The `dur` input is ignored after it is latched. Changing it mid-RUN has no effect.
- Requester contract: hold `req` until `done` or until cancelling; drop `req` in the cycle after `done`.
  - A `req` still high in the following IDLE cycle is a new request. It competes round-robin, so other requesters win first.
- Width rules:
  - Ticker counter is `$clog2(TICK)` bits. It counts 0..TICK-1 and wraps to 0 with a tick pulse.
  - `unit_cnt` is `DUR_W` bits and never wraps, because the compare to `dur_q` ends RUN first.
- Reset values (async assert, sync release):
  - State IDLE.
  - `grant`, `done`, `busy`, `owner`, `dur_q`, `unit_cnt`, ticker = 0.
  - `last_owner` = `N_REQ-1`, so requester 0 has first priority.
- Reset mid-RUN: all outputs are low immediately, with no `done`.

## Timing
- `req` is sampled in IDLE at edge k. `grant` and `busy` are high from cycle k+1 (registered outputs).
- RUN length is exactly `dur × TICK` cycles, or 1 cycle when `dur == 0`.
- `done` is high in the cycle right after the last RUN cycle. `grant` is low in that same cycle.
- Minimum spacing between grants is 3 cycles: DONE, IDLE, then RUN.
- Simultaneous events:
  - A tick that completes the count in the same cycle `req[owner]` falls: cancel wins, no `done`.
  - `req` rising on a non-owner during RUN has no effect until IDLE.

## Structure
- Shared package `timer_sched_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a round-robin pick function (request vector and last index → winner index and valid bit).
- One natural sub-module: `interval_ticker`.
  - Parameter `TICK`.
  - Ports `clk`, `rst_n`, `clr`, `en`, `tick`.
  - It replaces ad-hoc one-second counters elsewhere.
- Top level holds the FSM, the latches and `unit_cnt`.

## Test plan
All scenarios run with `TICK`=4, `N_REQ`=4.
1. Single request: `req`=0001, `dur0`=3 → `grant`=0001 for 12 cycles, `done`=0001 for 1 cycle, then `busy`=0.
2. Round-robin: `req`=1111 held and each requester drops `req` after its `done` → grants in order 0,1,2,3. With all reasserting, next order is 0,1,2,3 again; no requester is granted twice in a row while another waits.
3. Zero duration: `req`=0100, `dur2`=0 → `grant`=0100 for 1 cycle, then `done`=0100.
4. Cancel: `req1` with `dur`=5 is dropped after 7 RUN cycles → no `done`, IDLE next cycle; a pending `req2` is granted 1 cycle later.
5. Reset mid-RUN: `rst_n`=0 asynchronously during RUN → `grant`=0 and `busy`=0 immediately. After release, the first `req`=1010 grants requester 1 (pointer reset).
6. Change `dur` during RUN: `dur0` changes from 2 to 7 → RUN still lasts 8 cycles.
